// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared definitions for the multi-channel SPI master:
//               FSM state encoding, SPI mode constants ({cpol,cpha}) and
//               helpers that size the chip-select index and length fields.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Transfer sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_t;

    // SPI modes encoded as {cpol, cpha}.
    localparam logic [1:0] c_MODE0 = 2'b00;
    localparam logic [1:0] c_MODE1 = 2'b01;
    localparam logic [1:0] c_MODE2 = 2'b10;
    localparam logic [1:0] c_MODE3 = 2'b11;

    // Width of the chip-select index; a single CS still gets a 1-bit field.
    function automatic int sel_width(input int num_cs);
        return (num_cs > 1) ? $clog2(num_cs) : 1;
    endfunction

    // Width needed to hold a bit count of 0..max_bits.
    function automatic int len_width(input int max_bits);
        return $clog2(max_bits + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clk_tick.sv
`default_nettype none
// ============================================================================
// Module      : spi_clk_tick
// Description : Loadable half-period tick generator. On load the divider is
//               captured (0 is treated as 1); while enabled it emits a
//               single-cycle tick every D clk cycles, the first one D cycles
//               after the load.
// Ports       : clk, reset_n    - clock, async active-low reset
//               load, div       - capture a new divider value
//               en              - run the counter
//               tick            - one-cycle pulse every D enabled cycles
// Revision    : 1.0 - initial release
// ============================================================================
module spi_clk_tick #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 en,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] r_reload;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] w_div_m1;

    // Counter runs D-1 down to 0, so a divider of 0 behaves like 1.
    assign w_div_m1 = (div == '0) ? '0 : (div - DIV_WIDTH'(1));
    assign tick     = en && (r_cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_reload <= '0;
            r_cnt    <= '0;
        end else if (load) begin
            r_reload <= w_div_m1;
            r_cnt    <= w_div_m1;
        end else if (en) begin
            if (r_cnt == '0) begin
                r_cnt <= r_reload;
            end else begin
                r_cnt <= r_cnt - DIV_WIDTH'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_master_mc.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_mc
// Description : Multi-channel SPI master with runtime CPOL/CPHA, per-transfer
//               half-period divider, 1..MAX_BITS transfer length and one of
//               NUM_CS active-low chip selects. Each transfer is framed by a
//               CS setup, hold and gap of one half-period each.
// Ports       : clk, reset_n              - clock, async active-low reset
//               start, busy, done         - request / status handshake
//               cs_sel, cpol, cpha, div,
//               len, tx_data              - config, latched on start
//               rx_data                   - received word, right-aligned
//               spi_clk, spi_mosi,
//               spi_miso, spi_cs_n        - SPI bus
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_mc
    import spi_pkg::*;
#(
    parameter int NUM_CS    = 4,
    parameter int MAX_BITS  = 32,
    parameter int DIV_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    input  logic [sel_width(NUM_CS)-1:0]   cs_sel,
    input  logic                           cpol,
    input  logic                           cpha,
    input  logic [DIV_WIDTH-1:0]           div,
    input  logic [len_width(MAX_BITS)-1:0] len,
    input  logic [MAX_BITS-1:0]            tx_data,
    output logic [MAX_BITS-1:0]            rx_data,
    output logic                           spi_clk,
    output logic                           spi_mosi,
    input  logic                           spi_miso,
    output logic [NUM_CS-1:0]              spi_cs_n
);

    localparam int                 c_SEL_W   = sel_width(NUM_CS);
    localparam int                 c_LEN_W   = len_width(MAX_BITS);
    localparam logic [c_LEN_W-1:0] c_MAX_LEN = c_LEN_W'(MAX_BITS);

    spi_state_t            r_state;
    spi_state_t            w_next_state;

    logic                  r_cpol;
    logic                  r_cpha;
    logic                  r_sclk_tog;    // spi_clk = cpol ^ toggle
    logic                  r_phase;       // 0: next edge is leading, 1: trailing
    logic [c_LEN_W-1:0]    r_bits_left;
    logic [MAX_BITS-1:0]   r_tx;          // MSB-aligned, next bit at the top
    logic [MAX_BITS-1:0]   r_rx;
    logic [MAX_BITS-1:0]   r_rx_data;
    logic                  r_mosi;
    logic [NUM_CS-1:0]     r_cs_n;
    logic                  r_done;

    logic                  w_tick;
    logic                  w_tick_en;
    logic                  w_accept;
    logic                  w_edge;
    logic                  w_last_edge;
    logic                  w_sample;
    logic                  w_shift;
    logic                  w_release;
    logic                  w_finish;
    logic [c_LEN_W-1:0]    w_len_eff;
    logic [c_LEN_W-1:0]    w_shamt;
    logic [MAX_BITS-1:0]   w_tx_aligned;
    logic [NUM_CS-1:0]     w_cs_dec;

    // ------------------------------------------------------------------
    // Configuration decode
    // ------------------------------------------------------------------
    assign w_accept     = start && (r_state == ST_IDLE);
    assign w_len_eff    = (len > c_MAX_LEN) ? c_MAX_LEN : len;
    assign w_shamt      = c_MAX_LEN - w_len_eff;
    assign w_tx_aligned = tx_data << w_shamt;

    // An out-of-range cs_sel decodes to no select; the transfer still runs.
    for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
        assign w_cs_dec[gi] = (cs_sel == c_SEL_W'(gi));
    end

    // ------------------------------------------------------------------
    // Half-period timebase
    // ------------------------------------------------------------------
    assign w_tick_en = (r_state != ST_IDLE);

    spi_clk_tick #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (w_accept),
        .div     (div),
        .en      (w_tick_en),
        .tick    (w_tick)
    );

    // ------------------------------------------------------------------
    // Edge decode. The tick closing SETUP produces edge 1; the tick that
    // produces edge 2*len opens the HOLD half-period.
    // ------------------------------------------------------------------
    assign w_edge      = w_tick && ((r_state == ST_SETUP) || (r_state == ST_XFER));
    assign w_last_edge = r_phase && (r_bits_left == c_LEN_W'(1));
    assign w_sample    = w_edge && (r_cpha ? r_phase : !r_phase);
    assign w_shift     = w_edge && (r_cpha ? !r_phase : (r_phase && !w_last_edge));
    assign w_release   = w_tick && (r_state == ST_HOLD);
    assign w_finish    = w_tick && (r_state == ST_GAP);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (w_len_eff != '0)) begin
                    w_next_state = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (w_tick) begin
                    w_next_state = ST_XFER;
                end
            end
            ST_XFER: begin
                if (w_tick && w_last_edge) begin
                    w_next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_tick) begin
                    w_next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_tick) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_sclk_tog  <= 1'b0;
            r_phase     <= 1'b0;
            r_bits_left <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_rx_data   <= '0;
            r_mosi      <= 1'b0;
            r_cs_n      <= '1;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_cpol      <= cpol;
                r_cpha      <= cpha;
                r_sclk_tog  <= 1'b0;
                r_phase     <= 1'b0;
                r_bits_left <= w_len_eff;
                r_rx        <= '0;
                if (w_len_eff == '0) begin
                    // Zero-length request completes at once, bus untouched.
                    r_done    <= 1'b1;
                    r_rx_data <= '0;
                end else begin
                    r_cs_n <= ~w_cs_dec;
                    if (!cpha) begin
                        // First bit must be on the wire before the leading edge.
                        r_mosi <= w_tx_aligned[MAX_BITS-1];
                        r_tx   <= w_tx_aligned << 1;
                    end else begin
                        r_tx   <= w_tx_aligned;
                    end
                end
            end else begin
                if (w_edge) begin
                    r_sclk_tog <= !r_sclk_tog;
                    r_phase    <= !r_phase;
                    if (r_phase) begin
                        r_bits_left <= r_bits_left - c_LEN_W'(1);
                    end
                end
                if (w_sample) begin
                    r_rx <= (r_rx << 1) | MAX_BITS'(spi_miso);
                end
                if (w_shift) begin
                    r_mosi <= r_tx[MAX_BITS-1];
                    r_tx   <= r_tx << 1;
                end
                if (w_release) begin
                    r_cs_n <= '1;
                end
                if (w_finish) begin
                    r_done    <= 1'b1;
                    r_rx_data <= r_rx;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign rx_data  = r_rx_data;
    assign spi_clk  = r_cpol ^ r_sclk_tog;
    assign spi_mosi = r_mosi;
    assign spi_cs_n = r_cs_n;

endmodule
`default_nettype wire
